regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RW/en/busW) between two writeback requesters: req 0 = ALU writeback, req 1 = load writeback.
- Each requester has a valid/ready handshake and a 1-entry holding slot.
- A round-robin arbiter grants at most one write per cycle into a registered output stage that drives the register file.
- A pending-write mask is exported so decode/stall logic can detect RAW hazards on writes still in flight.

Parameters:
- DW, 32, write data width (busW width).
- AW, 5, register address width; NREG = 2**AW = 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [1:0]  write request valid, one bit per requester.
- req_ready  out  [1:0]  slot can accept this cycle.
- req_addr0, req_addr1  in  AW each  destination register.
- req_data0, req_data1  in  DW each  write data.
- RW  out  AW  register-file write address.
- en  out  1  register-file write enable.
- busW  out  DW  register-file write data.
- pending  out  NREG  bit r=1 while a write to register r is held or in the output stage.
- idle  out  1  no held entries and en=0.

Behaviour:
- Reset (async, rst_n=0):
  - Both slots are emptied and the output stage is cleared: RW=0, en=0, busW=0.
  - pending=0, idle=1, req_ready=2'b11 (ready is combinational from slot state).
  - last_grant=1, so req 0 wins the first conflict.
  - Reset mid-operation discards all held and staged writes. No partial write reaches the register file, because en drops immediately.
- Handshake:
  - A transfer on requester i occurs at a rising edge where req_valid[i]=1 and req_ready[i]=1.
  - req_ready[i] = !slot_valid[i] || grant[i]. The slot refills in the same cycle it is granted, giving full throughput.
  - A requester must hold addr/data stable while valid=1 and ready=0.
- Arbitration (combinational over slot_valid):
  - One slot valid: grant it.
  - Both valid: grant the slot not equal to last_grant. last_grant updates on every grant.
  - Neither valid: no grant.
- Output stage (registered at each edge):
  - If a grant occurs: RW<=slot.addr, busW<=slot.data, en<=(slot.addr!=0).
  - Otherwise en<=0; RW and busW hold their previous values.
- Register 0: writes to address 0 are accepted and consume a grant slot but never assert en.
- Latency: accept at edge N → output stage loaded at edge N+1 (uncontended) → register file writes at edge N+2. Worst-case wait under contention is one extra cycle.
- Ordering:
  - Writes from the same requester complete in acceptance order.
  - Same-address writes from different requesters complete in grant order; the later grant's data remains in the register.
- pending:
  - Set bit for each valid slot's addr, plus RW when en=1. Address 0 is never flagged.
  - Purely decoded from state; no counters.
- idle = !slot_valid[0] && !slot_valid[1] && !en.

Decomposition:
- Package regfile_pkg:
  - constants AW=5, NREG=32, DW=32.
  - typedef wb_req_t {logic [AW-1:0] addr; logic [DW-1:0] data;}.
  - function onehot_addr(addr) returning an NREG mask, used for pending (same decode as decoder5_32).
- Sub-module wb_hold_slot: 1-entry buffer with valid/ready in, grant/valid/entry out, async active-low reset. Instantiated twice.
- Top contains the round-robin logic, output register and pending mask.

Test Plan:
- Reset then req0 valid with addr=5, data=0xDEADBEEF, single cycle → en=1, RW=5, busW=0xDEADBEEF exactly two edges after acceptance, for one cycle; pending[5]=1 from edge N until en falls.
- Both requesters valid every cycle (req0 addr 1..4, req1 addr 17..20) → grants alternate 0,1,0,1 starting with req0; en stays high continuously; all 8 writes appear on RW in interleaved order; each req_ready toggles per grant.
- req1 addr=0, data=0xFFFFFFFF → accepted, occupies one output cycle with en=0; pending stays 0; idle returns to 1 afterwards.
- Same-cycle conflict on addr=9: req0 data=0x11, req1 data=0x22, last_grant=0 → req1 is written first, then req0; register 9 ends at 0x11.
- Back-to-back from req0 only: 6 consecutive valid cycles (addr 6..11) → req_ready stays 1, one write per cycle, no bubbles.
- Assert rst_n=0 asynchronously (between edges) with both slots full and en=1 → en, pending and req_ready update immediately; after release no stale write appears and idle=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths, writeback request type and address decode for the writeback arbiter
package regfile_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 2 ** AW;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;
  function automatic logic [NREG-1:0] onehot_addr(input logic [AW-1:0] addr);
    return {{(NREG-1){1'b0}}, 1'b1} << addr;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester handshakes plus register-file write port and hazard status
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [AW-1:0]   req_addr0;
  logic [AW-1:0]   req_addr1;
  logic [DW-1:0]   req_data0;
  logic [DW-1:0]   req_data1;
  logic [AW-1:0]   RW;
  logic            en;
  logic [DW-1:0]   busW;
  logic [NREG-1:0] pending;
  logic            idle;
  modport master (
    output req_valid, req_addr0, req_addr1, req_data0, req_data1,
    input  req_ready, RW, en, busW, pending, idle
  );
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
    output req_ready, RW, en, busW, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// wb_hold_slot: one-entry writeback buffer that refills in the same cycle it is granted
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  wb_req_t in_entry,
  input  logic    grant,
  output logic    ready,
  output logic    valid,
  output wb_req_t entry
);
  assign ready = !valid || grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (in_valid && ready) begin
      valid <= 1'b1;
      entry <= in_entry;
    end else if (grant) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU and load writeback
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);
  wb_req_t       in0, in1, e0, e1, sel;
  logic [1:0]    sv, grant, rdy;
  logic          last_grant, en_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] bw_q;
  assign in0 = {bus.req_addr0, bus.req_data0};
  assign in1 = {bus.req_addr1, bus.req_data1};
  wb_hold_slot u_slot0 (
    .clk(clk), .rst_n(rst_n), .in_valid(bus.req_valid[0]), .in_entry(in0),
    .grant(grant[0]), .ready(rdy[0]), .valid(sv[0]), .entry(e0)
  );
  wb_hold_slot u_slot1 (
    .clk(clk), .rst_n(rst_n), .in_valid(bus.req_valid[1]), .in_entry(in1),
    .grant(grant[1]), .ready(rdy[1]), .valid(sv[1]), .entry(e1)
  );
  // on contention the requester that did not win last time goes first
  assign grant[1] = sv[1] && (!sv[0] || !last_grant);
  assign grant[0] = sv[0] && !grant[1];
  assign sel = grant[1] ? e1 : e0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant <= 1'b1;
      en_q       <= 1'b0;
      rw_q       <= '0;
      bw_q       <= '0;
    end else begin
      en_q <= |grant && |sel.addr;
      if (|grant) begin
        last_grant <= grant[1];
        rw_q       <= sel.addr;
        bw_q       <= sel.data;
      end
    end
  assign bus.req_ready = rdy;
  assign bus.RW        = rw_q;
  assign bus.busW      = bw_q;
  assign bus.en        = en_q;
  assign bus.idle      = !(|sv) && !en_q;
  // register 0 is hard-wired, so it can never be a hazard
  assign bus.pending   = ((sv[0] ? onehot_addr(e0.addr) : '0) |
                          (sv[1] ? onehot_addr(e1.addr) : '0) |
                          (en_q  ? onehot_addr(rw_q)    : '0)) & {{(NREG-1){1'b1}}, 1'b0};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios with hand-computed expectations for the writeback arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vec = 0;
  int errs = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic idle_inputs;
    bus.req_valid = 2'b00;
    bus.req_addr0 = '0;
    bus.req_addr1 = '0;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL reset_en got %b want 0", bus.en); end
    vec++; if (bus.RW !== 5'd0) begin errs++; $display("FAIL reset_RW got %h want 0", bus.RW); end
    vec++; if (bus.busW !== 32'h0) begin errs++; $display("FAIL reset_busW got %h want 0", bus.busW); end
    vec++; if (bus.pending !== 32'h0) begin errs++; $display("FAIL reset_pending got %h want 0", bus.pending); end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL reset_idle got %b want 1", bus.idle); end
    vec++; if (bus.req_ready !== 2'b11) begin errs++; $display("FAIL reset_ready got %b want 11", bus.req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr0 = 5'd5;
    bus.req_data0 = 32'hDEADBEEF;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL single_en_n got %b want 0", bus.en); end
    vec++; if (bus.pending !== 32'h0000_0020) begin errs++; $display("FAIL single_pend_n got %h want 00000020", bus.pending); end
    vec++; if (bus.idle !== 1'b0) begin errs++; $display("FAIL single_idle_n got %b want 0", bus.idle); end
    @(negedge clk);
    vec++; if (bus.en !== 1'b1) begin errs++; $display("FAIL single_en_n1 got %b want 1", bus.en); end
    vec++; if (bus.RW !== 5'd5) begin errs++; $display("FAIL single_RW got %h want 05", bus.RW); end
    vec++; if (bus.busW !== 32'hDEADBEEF) begin errs++; $display("FAIL single_busW got %h want deadbeef", bus.busW); end
    vec++; if (bus.pending !== 32'h0000_0020) begin errs++; $display("FAIL single_pend_n1 got %h want 00000020", bus.pending); end
    @(negedge clk);
    vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL single_en_n2 got %b want 0", bus.en); end
    vec++; if (bus.pending !== 32'h0) begin errs++; $display("FAIL single_pend_n2 got %h want 0", bus.pending); end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL single_idle_n2 got %b want 1", bus.idle); end
  endtask

  task automatic test_interleave;
    logic [4:0] exp_rw [8] = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};
    logic [31:0] exp_bw [8] = '{32'hA000_0001, 32'hB000_0011, 32'hA000_0002, 32'hB000_0012,
                                32'hA000_0003, 32'hB000_0013, 32'hA000_0004, 32'hB000_0014};
    logic [1:0] rdy;
    int i0 = 0;
    int i1 = 0;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr0 = 5'd1;  bus.req_data0 = 32'hA000_0001;
    bus.req_addr1 = 5'd17; bus.req_data1 = 32'hB000_0011;
    rdy = bus.req_ready;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (bus.req_valid[0] && rdy[0]) i0++;
      if (bus.req_valid[1] && rdy[1]) i1++;
      bus.req_valid = {i1 < 4, i0 < 4};
      bus.req_addr0 = 5'(1 + i0);  bus.req_data0 = 32'hA000_0000 + 32'(1 + i0);
      bus.req_addr1 = 5'(17 + i1); bus.req_data1 = 32'hB000_0000 + 32'(17 + i1);
      @(negedge clk);
      if (c <= 7) begin
        vec++;
        if (bus.req_ready !== ((c % 2 == 1) ? 2'b01 : 2'b10)) begin
          errs++; $display("FAIL ilv_ready c=%0d got %b want %b", c, bus.req_ready, (c % 2 == 1) ? 2'b01 : 2'b10);
        end
      end
      if (c >= 2 && c <= 9) begin
        vec++;
        if (bus.en !== 1'b1 || bus.RW !== exp_rw[c-2] || bus.busW !== exp_bw[c-2]) begin
          errs++; $display("FAIL ilv_write c=%0d got en=%b RW=%0d busW=%h want en=1 RW=%0d busW=%h",
                           c, bus.en, bus.RW, bus.busW, exp_rw[c-2], exp_bw[c-2]);
        end
      end
      if (c >= 10) begin
        vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL ilv_tail_en c=%0d got %b want 0", c, bus.en); end
      end
      rdy = bus.req_ready;
    end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL ilv_idle got %b want 1", bus.idle); end
  endtask

  task automatic test_addr0;
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_addr1 = 5'd0;
    bus.req_data1 = 32'hFFFFFFFF;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    vec++; if (bus.pending !== 32'h0) begin errs++; $display("FAIL a0_pend_n got %h want 0", bus.pending); end
    vec++; if (bus.idle !== 1'b0) begin errs++; $display("FAIL a0_idle_n got %b want 0", bus.idle); end
    @(negedge clk);
    vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL a0_en got %b want 0", bus.en); end
    vec++; if (bus.busW !== 32'hFFFFFFFF) begin errs++; $display("FAIL a0_busW got %h want ffffffff", bus.busW); end
    vec++; if (bus.RW !== 5'd0) begin errs++; $display("FAIL a0_RW got %h want 0", bus.RW); end
    vec++; if (bus.pending !== 32'h0) begin errs++; $display("FAIL a0_pend_n1 got %h want 0", bus.pending); end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL a0_idle_n1 got %b want 1", bus.idle); end
  endtask

  task automatic test_conflict;
    logic [31:0] reg9 = 32'h0;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr0 = 5'd3;
    bus.req_data0 = 32'h33;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_addr0 = 5'd9; bus.req_data0 = 32'h11;
    bus.req_addr1 = 5'd9; bus.req_data1 = 32'h22;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    vec++; if (bus.pending !== 32'h0000_0200) begin errs++; $display("FAIL cf_pend got %h want 00000200", bus.pending); end
    @(negedge clk);
    if (bus.en === 1'b1 && bus.RW === 5'd9) reg9 = bus.busW;
    vec++; if (bus.en !== 1'b1 || bus.RW !== 5'd9 || bus.busW !== 32'h22) begin
      errs++; $display("FAIL cf_first got en=%b RW=%0d busW=%h want en=1 RW=9 busW=00000022", bus.en, bus.RW, bus.busW);
    end
    vec++; if (bus.pending !== 32'h0000_0200) begin errs++; $display("FAIL cf_pend2 got %h want 00000200", bus.pending); end
    @(negedge clk);
    if (bus.en === 1'b1 && bus.RW === 5'd9) reg9 = bus.busW;
    vec++; if (bus.en !== 1'b1 || bus.RW !== 5'd9 || bus.busW !== 32'h11) begin
      errs++; $display("FAIL cf_second got en=%b RW=%0d busW=%h want en=1 RW=9 busW=00000011", bus.en, bus.RW, bus.busW);
    end
    @(negedge clk);
    if (bus.en === 1'b1 && bus.RW === 5'd9) reg9 = bus.busW;
    vec++; if (reg9 !== 32'h11) begin errs++; $display("FAIL cf_reg9 got %h want 00000011", reg9); end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL cf_idle got %b want 1", bus.idle); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] rdy;
    int i0 = 0;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr0 = 5'd6;
    bus.req_data0 = 32'hC000_0006;
    rdy = bus.req_ready;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (bus.req_valid[0] && rdy[0]) i0++;
      bus.req_valid = {1'b0, i0 < 6};
      bus.req_addr0 = 5'(6 + i0);
      bus.req_data0 = 32'hC000_0000 + 32'(6 + i0);
      @(negedge clk);
      if (c <= 6) begin
        vec++; if (bus.req_ready !== 2'b11) begin errs++; $display("FAIL b2b_ready c=%0d got %b want 11", c, bus.req_ready); end
      end
      if (c >= 2 && c <= 7) begin
        vec++;
        if (bus.en !== 1'b1 || bus.RW !== 5'(4 + c) || bus.busW !== 32'hC000_0000 + 32'(4 + c)) begin
          errs++; $display("FAIL b2b_write c=%0d got en=%b RW=%0d busW=%h want en=1 RW=%0d", c, bus.en, bus.RW, bus.busW, 4 + c);
        end
      end
      rdy = bus.req_ready;
    end
    vec++; if (bus.en !== 1'b0 || bus.idle !== 1'b1) begin
      errs++; $display("FAIL b2b_tail got en=%b idle=%b want en=0 idle=1", bus.en, bus.idle);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr0 = 5'd12; bus.req_data0 = 32'h12;
    bus.req_addr1 = 5'd13; bus.req_data1 = 32'h13;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_addr0 = 5'd14; bus.req_data0 = 32'h14;
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    vec++; if (bus.en !== 1'b1 || bus.RW !== 5'd12) begin
      errs++; $display("FAIL ar_pre got en=%b RW=%0d want en=1 RW=12", bus.en, bus.RW);
    end
    vec++; if (bus.pending !== 32'h0000_7000) begin errs++; $display("FAIL ar_pre_pend got %h want 00007000", bus.pending); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if (bus.en !== 1'b0) begin errs++; $display("FAIL ar_en got %b want 0", bus.en); end
    vec++; if (bus.pending !== 32'h0) begin errs++; $display("FAIL ar_pend got %h want 0", bus.pending); end
    vec++; if (bus.req_ready !== 2'b11) begin errs++; $display("FAIL ar_ready got %b want 11", bus.req_ready); end
    vec++; if (bus.idle !== 1'b1) begin errs++; $display("FAIL ar_idle got %b want 1", bus.idle); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++; if (bus.en !== 1'b0 || bus.idle !== 1'b1) begin
        errs++; $display("FAIL ar_post c=%0d got en=%b idle=%b want en=0 idle=1", c, bus.en, bus.idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_addr0();
    test_conflict();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
